// File: rtl/tx_header_chain_param_ble.sv
// BLE header transmit chain: header bits -> HEC -> whitening -> REP repetition -> BPSK/QPSK symbols.
// Defining TX_HDR_WHITEN_BYPASS_EN adds a whiten_bypass input that is latched on start.
module tx_header_chain_param_ble #(
   parameter int RE_IM_SIZE = 12,
   parameter int HDR_BITS   = 10,
   parameter int REP        = 3,
   parameter int AMP        = 1024,
   parameter int CNT_W      = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [7:0]            uap,
   input  logic [5:0]            whiten_seed,
   input  logic                  qpsk_mode,
`ifdef TX_HDR_WHITEN_BYPASS_EN
   input  logic                  whiten_bypass,
`endif
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [RE_IM_SIZE-1:0] data_out_real,
   output logic [RE_IM_SIZE-1:0] data_out_imag,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      sym_count
);

   typedef enum logic [1:0] {IDLE, HDR, HEC, FLUSH} state_t;

   localparam logic [RE_IM_SIZE-1:0] POS_AMP = RE_IM_SIZE'(AMP);
   localparam logic [RE_IM_SIZE-1:0] NEG_AMP = RE_IM_SIZE'(-AMP);

   state_t     state;
   logic [7:0] hec;
   logic [6:0] w;
   logic       qpsk_l;
   logic       bypass_l;
   logic       bypass_in;
   logic [6:0] hdr_cnt;
   logic [2:0] hec_cnt;
   logic       hold_valid;
   logic       hold_bit;
   logic [2:0] rep_cnt;
   logic       half_valid;
   logic       half_bit;

   logic out_free, take, last_take, can_load, hdr_acc, hec_load, pad_emit;
   logic src_bit, white_bit;

`ifdef TX_HDR_WHITEN_BYPASS_EN
   assign bypass_in = whiten_bypass;
`else
   assign bypass_in = 1'b0;
`endif

   function automatic logic [RE_IM_SIZE-1:0] sym_of(input logic b);
      return b ? NEG_AMP : POS_AMP;
   endfunction

   // The hold register feeds the symbol stage; QPSK parks the first bit of a pair in half_bit.
   assign out_free  = !out_valid || out_ready;
   assign take      = hold_valid && (qpsk_l ? (!half_valid || out_free) : out_free);
   assign last_take = take && (rep_cnt == 3'(REP - 1));
   assign can_load  = !hold_valid || last_take;
   assign in_ready  = (state == HDR) && can_load;
   assign hdr_acc   = in_ready && in_valid;
   assign hec_load  = (state == HEC) && can_load;
   assign src_bit   = (state == HEC) ? hec[7] : in_data;
   assign white_bit = bypass_l ? src_bit : (src_bit ^ w[6]);
   assign pad_emit  = (state == FLUSH) && qpsk_l && !hold_valid && half_valid && out_free;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         hec           <= '0;
         w             <= '0;
         qpsk_l        <= 1'b0;
         bypass_l      <= 1'b0;
         hdr_cnt       <= '0;
         hec_cnt       <= '0;
         hold_valid    <= 1'b0;
         hold_bit      <= 1'b0;
         rep_cnt       <= '0;
         half_valid    <= 1'b0;
         half_bit      <= 1'b0;
         out_valid     <= 1'b0;
         data_out_real <= '0;
         data_out_imag <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         sym_count     <= '0;
      end else begin
         done <= 1'b0;
         if (out_valid && out_ready && sym_count != '1)
            sym_count <= sym_count + 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  hec        <= uap;
                  w          <= {1'b1, whiten_seed};
                  qpsk_l     <= qpsk_mode;
                  bypass_l   <= bypass_in;
                  hdr_cnt    <= '0;
                  hec_cnt    <= '0;
                  hold_valid <= 1'b0;
                  rep_cnt    <= '0;
                  half_valid <= 1'b0;
                  out_valid  <= 1'b0;
                  sym_count  <= '0;
                  busy       <= 1'b1;
                  state      <= HDR;
               end
            end
            default: begin
               if (abort) begin
                  hold_valid    <= 1'b0;
                  rep_cnt       <= '0;
                  half_valid    <= 1'b0;
                  out_valid     <= 1'b0;
                  data_out_real <= '0;
                  data_out_imag <= '0;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end else begin
                  if (out_valid && out_ready)
                     out_valid <= 1'b0;
                  if (take) begin
                     if (last_take) begin
                        hold_valid <= 1'b0;
                        rep_cnt    <= '0;
                     end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                     end
                     if (!qpsk_l) begin
                        out_valid     <= 1'b1;
                        data_out_real <= sym_of(hold_bit);
                        data_out_imag <= '0;
                     end else if (!half_valid) begin
                        half_valid <= 1'b1;
                        half_bit   <= hold_bit;
                     end else begin
                        out_valid     <= 1'b1;
                        data_out_real <= sym_of(half_bit);
                        data_out_imag <= sym_of(hold_bit);
                        half_valid    <= 1'b0;
                     end
                  end else if (pad_emit) begin
                     out_valid     <= 1'b1;
                     data_out_real <= sym_of(half_bit);
                     data_out_imag <= POS_AMP;
                     half_valid    <= 1'b0;
                  end
                  // A newly whitened bit refills the hold register and steps the whitening LFSR.
                  if (hdr_acc || hec_load) begin
                     hold_valid <= 1'b1;
                     hold_bit   <= white_bit;
                     rep_cnt    <= '0;
                     w          <= {w[5:4], w[3] ^ w[6], w[2:0], w[6]};
                  end
                  if (hdr_acc) begin
                     hec     <= {hec[6:0], 1'b0} ^ ((in_data ^ hec[7]) ? 8'hA7 : 8'h00);
                     hdr_cnt <= hdr_cnt + 1'b1;
                     if (hdr_cnt == 7'(HDR_BITS - 1))
                        state <= HEC;
                  end
                  if (hec_load) begin
                     hec     <= {hec[6:0], 1'b0};
                     hec_cnt <= hec_cnt + 1'b1;
                     if (hec_cnt == 3'd7)
                        state <= FLUSH;
                  end
                  if (state == FLUSH && out_valid && out_ready && !hold_valid && !half_valid) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_header_chain_param_ble.sv
// Randomized self-checking bench for tx_header_chain_param_ble against a queue-based symbol model.
module tb_tx_header_chain_param_ble;

   localparam int RE_IM_SIZE = 12;
   localparam int HDR_BITS   = 10;
   localparam int REP        = 3;
   localparam int AMP        = 1024;
   localparam int CNT_W      = 12;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  start = 1'b0;
   logic                  abort = 1'b0;
   logic [7:0]            uap = '0;
   logic [5:0]            whiten_seed = '0;
   logic                  qpsk_mode = 1'b0;
   logic                  whiten_bypass = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic                  in_data = 1'b0;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic [RE_IM_SIZE-1:0] data_out_real;
   logic [RE_IM_SIZE-1:0] data_out_imag;
   logic                  busy;
   logic                  done;
   logic [CNT_W-1:0]      sym_count;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;
   int rdy_phase = 0;
   int hs_count = 0;
   int done_count = 0;
   int first_re[12];
   int first_im[12];
   logic [2*RE_IM_SIZE-1:0] exp_q[$];

   tx_header_chain_param_ble #(
      .RE_IM_SIZE(RE_IM_SIZE), .HDR_BITS(HDR_BITS), .REP(REP), .AMP(AMP), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .uap(uap),
      .whiten_seed(whiten_seed), .qpsk_mode(qpsk_mode),
`ifdef TX_HDR_WHITEN_BYPASS_EN
      .whiten_bypass(whiten_bypass),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_out_real(data_out_real), .data_out_imag(data_out_imag),
      .busy(busy), .done(done), .sym_count(sym_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [RE_IM_SIZE-1:0] ampOf(input logic b);
      return b ? RE_IM_SIZE'(-AMP) : RE_IM_SIZE'(AMP);
   endfunction

   // Reference model: full bit stream (header + HEC), whitened, repeated, then grouped into symbols.
   task automatic buildExpected(input logic [63:0] hdr, input logic [7:0] u, input logic [5:0] s,
                                input logic q, input logic byp);
      logic [7:0] crc;
      logic [6:0] lfsr;
      logic       stream[$];
      logic       coded[$];
      logic       fb;
      logic       wb;
      crc = u;
      for (int i = 0; i < HDR_BITS; i++) begin
         stream.push_back(hdr[i]);
         fb  = hdr[i] ^ crc[7];
         crc = {crc[6:0], 1'b0} ^ (fb ? 8'hA7 : 8'h00);
      end
      for (int i = 7; i >= 0; i--) stream.push_back(crc[i]);
      lfsr = {1'b1, s};
      foreach (stream[k]) begin
         wb   = byp ? stream[k] : (stream[k] ^ lfsr[6]);
         lfsr = {lfsr[5:4], lfsr[3] ^ lfsr[6], lfsr[2:0], lfsr[6]};
         for (int r = 0; r < REP; r++) coded.push_back(wb);
      end
      if (!q) begin
         foreach (coded[k]) exp_q.push_back({ampOf(coded[k]), {RE_IM_SIZE{1'b0}}});
      end else begin
         for (int k = 0; k < coded.size(); k += 2)
            exp_q.push_back({ampOf(coded[k]), (k + 1 < coded.size()) ? ampOf(coded[k+1]) : ampOf(1'b0)});
      end
   endtask

   // Downstream ready pattern: always ready, random, or the 1-0-0-1 stall pattern.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: out_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
      endcase
      rdy_phase++;
   end

   // Every valid output must equal the model's head symbol until it is handshaken.
   always @(negedge clk) begin
      if (reset) begin
         if (done) done_count++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("extra_sym", 1, 0);
            end else begin
               checkOutput("sym", {data_out_real, data_out_imag}, exp_q[0]);
               if (out_ready) begin
                  if (hs_count < 12) begin
                     first_re[hs_count] = $signed(data_out_real);
                     first_im[hs_count] = $signed(data_out_imag);
                  end
                  void'(exp_q.pop_front());
                  hs_count++;
               end
            end
         end
      end
   end

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_in_ready"}, in_ready, 0);
      checkOutput({tag, "_out_valid"}, out_valid, 0);
      checkOutput({tag, "_real"}, data_out_real, 0);
      checkOutput({tag, "_imag"}, data_out_imag, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_sym_count"}, sym_count, 0);
   endtask

   // cut_kind: 0 none, 1 abort at header bit cut_at, 2 reset at header bit cut_at.
   task automatic applyStimulus(input logic [63:0] hdr, input logic [7:0] u, input logic [5:0] s,
                                input logic q, input logic byp, input int mode,
                                input int cut_kind, input int cut_at, input logic start_in_hec);
      int wait_cnt;
      int total;
      exp_q.delete();
      hs_count   = 0;
      done_count = 0;
      buildExpected(hdr, u, s, q, byp);
      total       = exp_q.size();
      rdy_mode    = mode;
      uap         = u;
      whiten_seed = s;
      qpsk_mode   = q;
      whiten_bypass = byp;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("busy_set", busy, 1);
      checkOutput("sym_count_clear", sym_count, 0);
      for (int i = 0; i < HDR_BITS; i++) begin
         in_valid = 1'b1;
         in_data  = hdr[i];
         wait_cnt = 0;
         @(negedge clk);
         while (!in_ready && wait_cnt < 500) begin
            @(negedge clk);
            wait_cnt++;
         end
         if (!in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            break;
         end
         if (i == cut_at && cut_kind == 1) begin
            abort = 1'b1;
            tick();
            abort    = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            checkOutput("abort_out_valid", out_valid, 0);
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_in_ready", in_ready, 0);
            checkOutput("abort_sym_hold", sym_count, hs_count);
            exp_q.delete();
            repeat (20) tick();
            checkOutput("abort_no_done", done_count, 0);
            return;
         end
         if (i == cut_at && cut_kind == 2) begin
            reset = 1'b0;
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            checkIdleZero("midreset");
            reset = 1'b1;
            exp_q.delete();
            tick();
            return;
         end
         tick();
         if (mode == 1) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      in_valid = 1'b0;
      if (start_in_hec) begin
         tick();
         tick();
         start     = 1'b1;
         qpsk_mode = ~q;
         uap       = ~u;
         tick();
         start = 1'b0;
      end
      wait_cnt = 0;
      while (!done && wait_cnt < 3000) begin
         tick();
         wait_cnt++;
      end
      checkOutput("done_seen", done, 1);
      checkOutput("busy_clear", busy, 0);
      repeat (3) tick();
      checkOutput("done_pulses", done_count, 1);
      checkOutput("sym_count", sym_count, hs_count);
      checkOutput("sym_total", hs_count, total);
      checkOutput("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      int ref12[12];
      ref12 = '{-1024, -1024, -1024, 1024, 1024, 1024, 1024, 1024, 1024, -1024, -1024, -1024};
      reset = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checkIdleZero("reset");
      reset = 1'b1;
      tick();

      $display("[TB] directed BPSK all-zero header");
      applyStimulus(64'd0, 8'h00, 6'd0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
      for (int k = 0; k < 12; k++) checkOutput("bpsk_first12", first_re[k], ref12[k]);
      checkOutput("bpsk_imag0", first_im[0], 0);
      checkOutput("bpsk_count54", hs_count, (HDR_BITS + 8) * REP);

      $display("[TB] directed QPSK all-zero header");
      applyStimulus(64'd0, 8'h00, 6'd0, 1'b1, 1'b0, 0, 0, -1, 1'b0);
      checkOutput("qpsk_first_re", first_re[0], -1024);
      checkOutput("qpsk_first_im", first_im[0], -1024);
      checkOutput("qpsk_count27", hs_count, ((HDR_BITS + 8) * REP + 1) / 2);

      $display("[TB] stall pattern");
      applyStimulus(64'd0, 8'h00, 6'd0, 1'b0, 1'b0, 2, 0, -1, 1'b0);
      applyStimulus({$urandom, $urandom}, 8'($urandom), 6'($urandom), 1'b1, 1'b0, 2, 0, -1, 1'b0);

      $display("[TB] abort at fifth header bit then full packet");
      applyStimulus(64'd0, 8'h00, 6'd0, 1'b0, 1'b0, 0, 1, 4, 1'b0);
      applyStimulus(64'd0, 8'h00, 6'd0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
      checkOutput("after_abort_54", hs_count, 54);

      $display("[TB] start during HEC");
      applyStimulus({$urandom, $urandom}, 8'($urandom), 6'($urandom), 1'b0, 1'b0, 0, 0, -1, 1'b1);

      $display("[TB] reset mid-header then full packet");
      applyStimulus({$urandom, $urandom}, 8'($urandom), 6'($urandom), 1'b1, 1'b0, 0, 2, 3, 1'b0);
      applyStimulus({$urandom, $urandom}, 8'($urandom), 6'($urandom), 1'b1, 1'b0, 1, 0, -1, 1'b0);

      $display("[TB] random packets");
      for (int n = 0; n < 8; n++)
         applyStimulus({$urandom, $urandom}, 8'($urandom), 6'($urandom), 1'($urandom_range(0, 1)),
                       1'b0, $urandom_range(0, 2), 0, -1, 1'b0);

`ifdef TX_HDR_WHITEN_BYPASS_EN
      $display("[TB] whitening bypass");
      applyStimulus(64'd0, 8'h00, 6'd0, 1'b0, 1'b1, 0, 0, -1, 1'b0);
      for (int k = 0; k < 12; k++) checkOutput("bypass_pos", first_re[k], 1024);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_header_chain_param_ble.md
Name: tx_header_chain_param_ble

Overview:
Parametrised BLE/BT packet-header transmit chain, the successor to the fixed header transmitter.
- Serial path: header bits, then HEC generation, whitening, REP-fold repetition encoding, then BPSK or QPSK mapping.
- Ready/valid on input and output; runtime-selectable modulation; abort; per-packet symbol counter.
- Sits between the link-layer header serializer and the TX symbol multiplexer.

Parameters:
- RE_IM_SIZE, 12, width of signed I/Q output samples.
- HDR_BITS, 10, header payload bits per packet (1..64).
- REP, 3, repetition factor per coded bit (1..7).
- AMP, 1024, constellation magnitude; must fit in RE_IM_SIZE-1 bits.
- CNT_W, 12, width of the symbol counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; latches config, begins packet (ignored unless IDLE).
- abort  in  1  return to IDLE next cycle, no done pulse.
- uap  in  8  HEC LFSR seed.
- whiten_seed  in  6  whitening seed, low bits.
- qpsk_mode  in  1  0 = BPSK, 1 = QPSK.
- in_valid  in  1  header bit valid.
- in_ready  out  1  chain accepts header bit.
- in_data  in  1  header bit, LSB first.
- out_valid  out  1  symbol valid.
- out_ready  in  1  downstream accepts symbol.
- data_out_real  out  RE_IM_SIZE  I sample, two's complement.
- data_out_imag  out  RE_IM_SIZE  Q sample, two's complement.
- busy  out  1  packet in progress.
- done  out  1  one-cycle pulse after last symbol handshake.
- sym_count  out  CNT_W  symbols accepted downstream this packet.

Behaviour:
- Reset (reset=0 at posedge):
  - State IDLE.
  - All outputs 0: in_ready, out_valid, data_out_real/imag, busy, done, sym_count.
  - All LFSRs, counters and holding registers cleared.
  - Reset mid-packet discards everything.
- FSM: IDLE -> HDR -> HEC -> FLUSH -> IDLE.
  - IDLE: on start, latch uap into hec[7:0], load w[6:0]={1,whiten_seed}, latch qpsk_mode, clear sym_count, set busy; go to HDR.
  - HDR: accept HDR_BITS bits via in_valid&&in_ready; after the last, go to HEC.
  - HEC: source 8 internal bits hec[7] first, shifting left; go to FLUSH after the 8th.
  - FLUSH: wait for the last symbol handshake; pulse done 1 cycle, clear busy, go to IDLE.
- HEC update per header bit b:
  - fb=b^hec[7]
  - hec <= {hec[6:0],1'b0} ^ (fb ? 8'hA7 : 8'h00)
- Whitening, applied to header and HEC bits:
  - out = bit ^ w[6]
  - w <= {w[5:4], w[3]^w[6], w[2:0], w[6]}
- Repetition:
  - Whitened bit enters a 1-entry hold register with a 3-bit repeat counter.
  - Emits REP coded bits, one per cycle when the symbol stage is not stalled.
  - in_ready=1 only in HDR with hold empty, or on the final repeat being consumed.
- Symbol stage:
  - BPSK: every coded bit is a symbol; bit0 -> +AMP, bit1 -> -AMP; imag=0.
  - QPSK: first coded bit -> real, second -> imag; same sign rule.
  - QPSK with odd total coded bits: final symbol padded with imag bit 0 (+AMP).
- Output register:
  - Holds data stable while out_valid&&!out_ready.
  - Max throughput: 1 coded bit/cycle (BPSK 1 sym/cycle, QPSK 1 sym/2 cycles).
- Latency: first symbol out_valid 2 cycles after first in_valid&&in_ready (BPSK) or 3 cycles (QPSK).
- sym_count increments per out_valid&&out_ready; saturates at all-ones.
- Total symbols per packet: BPSK (HDR_BITS+8)*REP; QPSK ceil of that /2.
- abort: in any non-IDLE state, clears pipeline, out_valid, in_ready and busy next cycle; sym_count holds its value.
- start while non-IDLE: ignored. start and abort in the same cycle in IDLE: start wins.
- in_data ignored when in_ready=0.

Optional Feature:
- TX_HDR_WHITEN_BYPASS_EN defined:
  - Adds input port whiten_bypass (1), latched on start.
  - When latched 1, whitening output equals its input; the LFSR is still clocked.
- Undefined: port absent; whitening always applied.

Test Plan:
- BPSK, REP=3, uap=0x00, seed=0, header all 0 -> first 12 real samples: -1024 x3, +1024 x6, -1024 x3; imag=0; total 54 symbols; sym_count=54; done one pulse.
- QPSK, same stimulus -> 27 symbols; first sample (-1024,-1024); sym_count=27; busy low after done.
- out_ready toggled 1-0-0-1 each symbol -> samples stable while stalled; no duplicate or lost symbols; in_ready drops while the hold register is occupied.
- abort asserted at the 5th header bit -> out_valid=0, busy=0 next cycle; no done; next start produces a full 54-symbol packet.
- start pulsed during HEC -> ignored, packet completes normally; reset=0 mid-HDR -> all outputs 0 next cycle.
- With TX_HDR_WHITEN_BYPASS_EN, whiten_bypass=1, uap=0, header all 0, BPSK -> all 54 samples +1024.
